// File: rtl/tb_axi_stream_slave_pkg.sv
// tb_axi_stream_slave_pkg: shared widths and drain FSM states for the stream-to-diag bridge
package tb_axi_stream_slave_pkg;
  localparam int DATA_W = 16;
  localparam int DIAG_W = 8;
  localparam int ENTRY_W = DATA_W + 1;
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} drain_state_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock show-ahead FIFO with occupancy count
module axis_sync_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // storage write, no reset needed since count gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally; count stays put on simultaneous push and pop
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/tb_axi_stream_slave.sv
// tb_axi_stream_slave: AXI-Stream sink that reports each 16-bit word as two diag bytes, MSB first
module tb_axi_stream_slave
  import tb_axi_stream_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic [DIAG_W-1:0] o_diag,
  output logic              o_diag_wr,
  output logic              o_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic rst, push, pop, full, empty, last_seen, diag_wr_next, unused_aclk;
  logic [ENTRY_W-1:0] head, hold;
  logic [CW-1:0] count, count_next;
  logic [DIAG_W-1:0] diag_next;
  drain_state_t state, state_next;
  assign unused_aclk = s_axis_aclk;
  assign rst = i_rst | ~s_axis_aresetn;
  assign push = s_axis_tvalid & s_axis_tready & ~full;
  assign count_next = count + CW'(push) - CW'(pop);
  axis_sync_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({s_axis_tlast, s_axis_tdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // drain sequencing: pop into hold, emit MSB then LSB, chain straight into the next word when available
  always_comb begin
    state_next = state;
    pop = 1'b0;
    diag_next = o_diag;
    diag_wr_next = 1'b0;
    case (state)
      IDLE: begin
        pop = ~empty;
        state_next = empty ? IDLE : HI;
      end
      HI: begin
        diag_wr_next = 1'b1;
        diag_next = hold[DATA_W-1 -: DIAG_W];
        state_next = LO;
      end
      LO: begin
        diag_wr_next = 1'b1;
        diag_next = hold[DIAG_W-1:0];
        pop = ~hold[DATA_W] & ~empty;
        state_next = hold[DATA_W] ? DONE : (empty ? IDLE : HI);
      end
      default: state_next = DONE;
    endcase
  end
  // registered outputs; tready looks ahead at next occupancy so a full FIFO is never pushed
  always_ff @(posedge i_clk)
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      o_diag <= '0;
      o_diag_wr <= 1'b0;
      o_done <= 1'b0;
      last_seen <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) hold <= head;
      o_diag <= diag_next;
      o_diag_wr <= diag_wr_next;
      o_done <= o_done | (state == DONE);
      last_seen <= last_seen | (push & s_axis_tlast);
      s_axis_tready <= ~(last_seen | (push & s_axis_tlast)) & (count_next != CW'(FIFO_DEPTH));
    end
endmodule

// File: tb/tb_tb_axi_stream_slave.sv
// tb_tb_axi_stream_slave: table, directed and random checks of the stream-to-diag bridge
module tb_tb_axi_stream_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aresetn = 1'b1;
  logic tvalid = 1'b0;
  logic tlast = 1'b0;
  logic [15:0] tdata = '0;
  logic tready, diag_wr, done;
  logic [7:0] diag;

  always #5 clk = ~clk;

  tb_axi_stream_slave #(.FIFO_DEPTH(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .s_axis_aclk(clk),
    .s_axis_aresetn(aresetn),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast(tlast),
    .s_axis_tdata(tdata),
    .o_diag(diag),
    .o_diag_wr(diag_wr),
    .o_done(done)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          gap;
    logic [7:0]  msb;
    logic [7:0]  lsb;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, done_cyc = -1;
  logic [8:0] exp_q[$];
  logic [7:0] seen[$];
  int seen_cyc[$];
  bit acc_flag, exp_done, done_due, tlast_seen, prev_in_rst, ready_dropped;
  logic [7:0] last_diag = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every accepted word becomes two expected bytes, the tlast LSB arms o_done.
  task automatic monitor();
    logic [8:0] e;
    bit in_rst;
    in_rst = rst || !aresetn;
    cyc++;
    acc_flag = 0;
    if (prev_in_rst) check("tready_low_after_reset_edge", tready, 0);
    if (diag_wr) begin
      seen.push_back(diag);
      seen_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_byte: got %02h expected no write (cycle %0d)", diag, cyc);
      end else begin
        e = exp_q.pop_front();
        check("byte", diag, e[7:0]);
        done_due = e[8];
      end
      last_diag = diag;
    end else check("diag_hold", diag, last_diag);
    check("done", done, exp_done);
    if (done && done_cyc < 0) done_cyc = cyc;
    if (done_due) exp_done = 1;
    done_due = 0;
    if (tlast_seen) check("tready_after_tlast", tready, 0);
    if (!in_rst && tvalid && tready) begin
      acc_flag = 1;
      acc_cyc = cyc;
      exp_q.push_back({1'b0, tdata[15:8]});
      exp_q.push_back({tlast, tdata[7:0]});
      if (tlast) tlast_seen = 1;
    end
    if (!in_rst && tvalid && !tready) ready_dropped = 1;
    if (in_rst) begin
      exp_q.delete();
      exp_done = 0;
      tlast_seen = 0;
      last_diag = '0;
    end
    prev_in_rst = in_rst;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    seen.delete();
    seen_cyc.delete();
    done_cyc = -1;
    ready_dropped = 0;
  endtask

  task automatic idle(input int n);
    tvalid = 0;
    tlast = 0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2);
    check("rst_tready", tready, 0);
    check("rst_diag", diag, 0);
    check("rst_diag_wr", diag_wr, 0);
    check("rst_done", done, 0);
    rst = 0;
    step();
    check("tready_after_release", tready, 1);
    clear_log();
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bit ok;
    ok = 0;
    tvalid = 1;
    tdata = d;
    tlast = l;
    for (int k = 0; k < 100; k++) begin
      step();
      if (acc_flag) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no handshake expected accept of %04h", d);
    end
  endtask

  initial begin
    vec_t tab[10];
    int a, gaps, n;
    tab = '{'{16'h0051, 1'b0, 9, 8'h00, 8'h51}, '{16'h0040, 1'b0, 8, 8'h00, 8'h40},
            '{16'h0031, 1'b0, 7, 8'h00, 8'h31}, '{16'h0024, 1'b0, 6, 8'h00, 8'h24},
            '{16'h0019, 1'b0, 5, 8'h00, 8'h19}, '{16'h0010, 1'b0, 4, 8'h00, 8'h10},
            '{16'h0009, 1'b0, 3, 8'h00, 8'h09}, '{16'h0004, 1'b0, 2, 8'h00, 8'h04},
            '{16'h0001, 1'b0, 1, 8'h00, 8'h01}, '{16'h0000, 1'b1, 0, 8'h00, 8'h00}};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(tab[i].data, tab[i].last);
      idle(tab[i].gap);
    end
    idle(20);
    check("tab_count", seen.size(), 20);
    if (seen.size() == 20)
      for (int i = 0; i < 10; i++) begin
        check("tab_msb", seen[2*i], tab[i].msb);
        check("tab_lsb", seen[2*i+1], tab[i].lsb);
      end
    check("tab_done", done, 1);

    do_reset();
    for (int i = 0; i < 8; i++) send(16'h1234 + 16'(i), i == 7);
    idle(30);
    check("burst_tready_dropped", ready_dropped, 1);
    check("burst_count", seen.size(), 16);
    gaps = 0;
    if (seen.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        check("burst_msb", seen[2*i], 8'h12);
        check("burst_lsb", seen[2*i+1], 8'h34 + 8'(i));
      end
      for (int i = 0; i < 15; i++) if (seen_cyc[i+1] != seen_cyc[i] + 1) gaps++;
    end
    check("burst_no_gap", gaps, 0);
    check("burst_done", done, 1);

    do_reset();
    send(16'hABCD, 1);
    a = acc_cyc;
    idle(10);
    check("single_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("single_msb_lat", seen_cyc[0], a + 3);
      check("single_lsb_lat", seen_cyc[1], a + 4);
    end
    check("single_done_lat", done_cyc, a + 5);
    check("single_tready_stays_low", tready, 0);

    do_reset();
    send(16'h1111, 0);
    send(16'h2222, 0);
    send(16'h3333, 0);
    tvalid = 0;
    aresetn = 0;
    idle(2);
    aresetn = 1;
    step();
    clear_log();
    idle(10);
    check("abort_no_bytes", seen.size(), 0);
    check("abort_no_done", done, 0);
    send(16'h00FF, 1);
    idle(10);
    check("abort_new_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("abort_new_msb", seen[0], 8'h00);
      check("abort_new_lsb", seen[1], 8'hFF);
    end
    check("abort_new_done", done, 1);

    do_reset();
    idle(40);
    check("quiet_no_bytes", seen.size(), 0);
    check("quiet_done", done, 0);
    check("quiet_tready", tready, 1);

    for (int f = 0; f < 6; f++) begin
      do_reset();
      n = $urandom_range(1, 12);
      for (int w = 0; w < n; w++) begin
        send(16'($urandom), w == n - 1);
        idle($urandom_range(0, 3));
      end
      idle(20);
      check("rand_drained", exp_q.size(), 0);
      check("rand_count", seen.size(), 2 * n);
      check("rand_done", done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tb_axi_stream_slave.md
TB_AXI_STREAM_SLAVE -- requirements
Module: tb_axi_stream_slave

Interface
REQ-001 The block SHALL have one parameter, FIFO_DEPTH, default 4, meaning the number of stored stream words; it is a power of two and at least 2.
REQ-002 The port list SHALL be as follows, clock and reset first:
- i_clk  input  1  processor clock; the only clock.
- i_rst  input  1  synchronous reset, active-high.
- s_axis_aclk  input  1  stream clock; SHALL be driven by the same net as i_clk, is not used as a separate clock domain, and has no CDC logic.
- s_axis_aresetn  input  1  stream reset, active-low; the effective internal reset SHALL be i_rst OR NOT s_axis_aresetn, sampled synchronously on i_clk.
- s_axis_tvalid  input  1  stream word valid.
- s_axis_tready  output  1  block can accept a word.
- s_axis_tlast  input  1  final word of the frame.
- s_axis_tdata  input  16  stream word.
- o_diag  output  8  diagnostic byte.
- o_diag_wr  output  1  one-cycle strobe; o_diag is valid while it is high.
- o_done  output  1  frame fully reported; sticky.
REQ-003 Clocking and reset SHALL be one clock with a synchronous, active-high reset.

Function
REQ-004 A word SHALL be accepted on a rising edge where s_axis_tvalid and s_axis_tready are both high; the 17-bit entry {tlast, tdata} is written into the FIFO.
REQ-005 s_axis_tready SHALL be registered and high only when all of these hold: not in reset, FIFO not full, and no tlast word accepted since reset.
REQ-006 The drain FSM SHALL have the states IDLE, HI, LO and DONE.
- IDLE: when the FIFO is non-empty, pop the head entry into a holding register and go to HI.
- HI: drive o_diag = data[15:8] with o_diag_wr high, then go to LO.
- LO: drive o_diag = data[7:0] with o_diag_wr high.
  - Held tlast = 1: go to DONE.
  - Held tlast = 0 and FIFO non-empty: pop the next entry and go to HI (back-to-back, no gap).
  - Otherwise: go to IDLE.
- DONE: terminal until reset; o_done = 1; no pops and no writes.
REQ-007 o_diag and o_diag_wr SHALL be registered.
- A word accepted at edge N SHALL produce its MSB write in the cycle after edge N+2 and its LSB write in the cycle after edge N+3, provided the FSM was in IDLE.
- Sustained throughput SHALL be one word per 2 cycles.
REQ-008 o_diag_wr SHALL be high for exactly one cycle per byte; o_diag SHALL hold its last value when o_diag_wr is low.
REQ-009 o_done SHALL rise in the cycle after the LSB write of the tlast word and stay high until reset.
REQ-010 On a simultaneous push and pop, the FIFO count SHALL be unchanged; a push when full SHALL be impossible by construction (tready is low).
REQ-011 Byte order SHALL be MSB first; no bytes SHALL be dropped, duplicated or reordered.

Reset
REQ-012 During reset, all of the following SHALL hold:
- FIFO is emptied (pointers and count = 0).
- FSM is in IDLE.
- s_axis_tready = 0, o_diag = 8'h00, o_diag_wr = 0, o_done = 0.
- The tlast-seen flag is cleared.
REQ-013 Reset asserted mid-frame SHALL discard buffered and in-progress words without emitting further bytes.
REQ-014 s_axis_tready SHALL go high no earlier than the first edge after reset deasserts.

Structure
REQ-015 A shared package SHALL hold:
- constants DATA_W = 16 and DIAG_W = 8;
- the FIFO entry width (DATA_W + 1);
- the drain FSM state enumeration.
REQ-016 The FIFO SHALL be one sub-module, axis_sync_fifo, parameterised by width and depth, with full, empty, push and pop ports; the FSM and handshake SHALL live in the top level.

Verification
REQ-017 Ten-word frame with data 0x0051, 0x0040, 0x0031, 0x0024, 0x0019, 0x0010, 0x0009, 0x0004, 0x0001, 0x0000 (tlast on the last word) and a gap of 9 down to 0 idle cycles after each word -> o_diag write sequence 00 51 00 40 00 31 00 24 00 19 00 10 00 09 00 04 00 01 00 00, then o_done = 1.
REQ-018 tvalid held high continuously for 8 words 0x1234..0x123B -> tready drops when the FIFO is full; all 16 bytes are emitted in order with no gaps between writes.
REQ-019 Single word 0xABCD with tlast accepted at edge N -> AB written after edge N+2, CD after edge N+3, o_done after edge N+4, and tready stays 0 afterwards.
REQ-020 s_axis_aresetn pulsed low while 3 words are buffered -> no further o_diag_wr; after release, a new frame 0x00FF with tlast -> 00 FF, then o_done.
REQ-021 tvalid low throughout -> o_diag_wr and o_done stay 0 indefinitely, and tready stays 1.
